network_packet_assembler: RTL and testbench
===========================================

# network_packet_assembler

Sits directly downstream of the network ejector. Consumes its packed flit stream over valid/ready and reassembles flits into complete packets: header up to tail, bounded by a maximum packet length. Presents each packet to the sink as one wide word plus flit count, broadcast flag and virtual network id. Flags protocol violations (orphan flits, truncated packets, overlong packets, VN mismatch) and discards the offending flits.

## Interface
- NetworkIfFlitWidth, 64: flit size in bits.
- NetworkIfFlitTypeWidth, 2: flit type size. Encoding: 0 header, 1 payload, 2 tail, 3 header_tail.
- NetworkIfBroadcastWidth, 1: broadcast field size.
- NetworkIfVirtualNetworkIdWidth, 2: virtual network id size.
- MaxFlitsPerPacket, 4: maximum flits per packet, header included (≥1).
- NetworkIfDataWidth (local): sum of the four field widths. Packing from LSB: flit, flit_type, broadcast, vn_id.
- CountWidth (local): $clog2(MaxFlitsPerPacket+1).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  ejector data valid.
- ready_o  out  1  assembler can accept a flit.
- data_i  in  NetworkIfDataWidth  packed flit word.
- packet_valid_o  out  1  assembled packet available.
- packet_ready_i  in  1  sink accepts packet.
- packet_data_o  out  MaxFlitsPerPacket*NetworkIfFlitWidth  flit k in bits [k*W +: W]; header is slot 0.
- packet_num_flits_o  out  CountWidth  number of valid flits (1..Max).
- packet_broadcast_o  out  NetworkIfBroadcastWidth  broadcast field of the header.
- packet_virtual_network_id_o  out  NetworkIfVirtualNetworkIdWidth  VN of the header.
- error_o  out  1  one-cycle pulse on any protocol error.

## Operation
- A flit is accepted when valid_i && ready_o.
- ready_o = (state != OUTPUT).
- FSM states: IDLE, COLLECT, DROP, OUTPUT.
- IDLE:
  - header: store in slot 0, count=1, latch broadcast/VN, go to COLLECT.
  - header_tail: store in slot 0, count=1, go to OUTPUT.
  - payload/tail: drop, pulse error_o, stay in IDLE.
- COLLECT, payload or tail with VN equal to the latched VN:
  - If count < Max: store in slot[count], count+1. Tail goes to OUTPUT; payload stays in COLLECT.
  - If count == Max: pulse error_o, discard the partial packet. Payload goes to DROP; tail goes to IDLE.
- COLLECT, VN mismatch: drop the flit, pulse error_o, stay in COLLECT. Count is unchanged.
- COLLECT, header or header_tail: pulse error_o and discard the partial packet. The new flit is processed exactly as in IDLE in the same cycle.
- DROP: discard every flit.
  - tail: go to IDLE.
  - header/header_tail: pulse error_o, process as in IDLE.
- OUTPUT: packet_valid_o=1. On packet_ready_i, go to IDLE.
- Slots at index ≥ count read as zero. All slots are cleared when a new header is stored.
- Only one error pulse per cycle; multiple causes in one cycle still give a single pulse.

## Timing
- Reset values: packet_valid_o=0, packet_data_o=0, packet_num_flits_o=0, packet_broadcast_o=0, packet_virtual_network_id_o=0, error_o=0, state IDLE, count 0.
- ready_o=1 in the first cycle after reset deasserts.
- Reset mid-packet or during OUTPUT discards all state with no error pulse.
- Latency: tail (or header_tail) accepted in cycle t gives packet_valid_o=1 in cycle t+1.
- No bypass: ready_o=0 from t+1 until packet acceptance.
- Packet accepted in cycle u gives ready_o=1 in u+1.
- Throughput: an n-flit packet occupies n+1 cycles minimum with an always-ready sink.
- packet outputs are stable while packet_valid_o && !packet_ready_i. packet_valid_o never drops without acceptance.
- error_o is asserted in the cycle after the offending flit is accepted.
- ready_o depends only on state, not combinationally on valid_i or packet_ready_i.

## Test plan
- Defaults, packet_ready_i=1. Send header(0xA), payload(0xB), tail(0xC) on VN 2 with broadcast=1 back-to-back -> one packet with num_flits=3, slots {0,0xC,0xB,0xA} from MSB, VN=2, broadcast=1, error_o never high. ready_o low exactly one cycle.
- header_tail 0x55 with packet_ready_i held 0 for 5 cycles -> packet_valid_o stays 1 with outputs stable and ready_o=0. Packet is released the cycle after ready, num_flits=1.
- Send a stray payload, then a tail, in IDLE -> two error pulses, no packet, ready_o stays 1.
- Send header + 4 payloads + tail (6 flits, Max=4) -> error pulse on the 5th flit, remaining flits dropped, no packet. A following header_tail is delivered normally.
- Send header(VN1), payload(VN3), tail(VN1) -> one error pulse, packet num_flits=2 with slots header/tail.
- Send header then a new header before the tail -> one error pulse; the second packet is assembled correctly. Assert rst_i mid-packet -> all outputs zero next cycle and no error.

Source files
------------

// File: rtl/network_packet_assembler_if.sv
// -----------------------------------------------------------------------------
// network_packet_assembler_if
//
// Purpose : Bundles the flit-side and packet-side signals of the packet
//           assembler. Signal names follow the assembler's point of view
//           (_i = driven into the assembler, _o = driven by it).
//
// Signals :
//   valid_i / ready_o / data_i      packed flit stream from the network ejector
//   packet_valid_o / packet_ready_i packet handshake towards the sink
//   packet_data_o                   flit k in bits [k*W +: W], header in slot 0
//   packet_num_flits_o              number of valid flits in the packet
//   packet_broadcast_o              broadcast field of the header
//   packet_virtual_network_id_o     virtual network of the header
//   error_o                         one-cycle protocol-error pulse
//
// Modports:
//   slave  - the assembler
//   master - the environment (ejector + sink)
// -----------------------------------------------------------------------------
interface network_packet_assembler_if #(
    parameter int NetworkIfFlitWidth             = 64,
    parameter int NetworkIfFlitTypeWidth         = 2,
    parameter int NetworkIfBroadcastWidth        = 1,
    parameter int NetworkIfVirtualNetworkIdWidth = 2,
    parameter int MaxFlitsPerPacket              = 4
);
    localparam int NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth
                                      + NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth;
    localparam int CountWidth         = $clog2(MaxFlitsPerPacket + 1);

    logic                                            valid_i;
    logic                                            ready_o;
    logic [NetworkIfDataWidth-1:0]                   data_i;
    logic                                            packet_valid_o;
    logic                                            packet_ready_i;
    logic [MaxFlitsPerPacket*NetworkIfFlitWidth-1:0] packet_data_o;
    logic [CountWidth-1:0]                           packet_num_flits_o;
    logic [NetworkIfBroadcastWidth-1:0]              packet_broadcast_o;
    logic [NetworkIfVirtualNetworkIdWidth-1:0]       packet_virtual_network_id_o;
    logic                                            error_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  packet_ready_i,
        output ready_o,
        output packet_valid_o,
        output packet_data_o,
        output packet_num_flits_o,
        output packet_broadcast_o,
        output packet_virtual_network_id_o,
        output error_o
    );

    modport master (
        output valid_i,
        output data_i,
        output packet_ready_i,
        input  ready_o,
        input  packet_valid_o,
        input  packet_data_o,
        input  packet_num_flits_o,
        input  packet_broadcast_o,
        input  packet_virtual_network_id_o,
        input  error_o
    );
endinterface

// File: rtl/network_packet_assembler.sv
// -----------------------------------------------------------------------------
// network_packet_assembler
//
// Purpose : Reassembles the flit stream leaving the network ejector into
//           complete packets (header .. tail, at most MaxFlitsPerPacket flits)
//           and presents each packet as one wide word with flit count,
//           broadcast flag and virtual network id. Orphan flits, truncated
//           packets, overlong packets and VN mismatches raise a one-cycle
//           error pulse and the offending flits are discarded.
//
// Ports   :
//   clk_i  - single clock, rising edge
//   rst_i  - synchronous, active-high reset
//   bus    - network_packet_assembler_if.slave (flit input, packet output,
//            error pulse)
// -----------------------------------------------------------------------------
module network_packet_assembler #(
    parameter int NetworkIfFlitWidth             = 64,
    parameter int NetworkIfFlitTypeWidth         = 2,
    parameter int NetworkIfBroadcastWidth        = 1,
    parameter int NetworkIfVirtualNetworkIdWidth = 2,
    parameter int MaxFlitsPerPacket              = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    network_packet_assembler_if.slave     bus
);
    localparam int CountWidth   = $clog2(MaxFlitsPerPacket + 1);
    localparam int SlotIdxWidth = (MaxFlitsPerPacket > 1) ? $clog2(MaxFlitsPerPacket) : 1;

    localparam int TypeLsb  = NetworkIfFlitWidth;
    localparam int BcastLsb = TypeLsb + NetworkIfFlitTypeWidth;
    localparam int VnLsb    = BcastLsb + NetworkIfBroadcastWidth;

    localparam logic [NetworkIfFlitTypeWidth-1:0] FtHeader     = NetworkIfFlitTypeWidth'(0);
    localparam logic [NetworkIfFlitTypeWidth-1:0] FtTail       = NetworkIfFlitTypeWidth'(2);
    localparam logic [NetworkIfFlitTypeWidth-1:0] FtHeaderTail = NetworkIfFlitTypeWidth'(3);

    localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxFlitsPerPacket);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DROP,
        OUTPUT
    } state_e;

    state_e                                          state_q, state_d;
    logic [CountWidth-1:0]                           count_q, count_d;
    logic [MaxFlitsPerPacket-1:0][NetworkIfFlitWidth-1:0] slots_q, slots_d;
    logic [NetworkIfBroadcastWidth-1:0]              bcast_q, bcast_d;
    logic [NetworkIfVirtualNetworkIdWidth-1:0]       vn_q, vn_d;
    logic                                            error_q, error_d;

    logic [NetworkIfFlitWidth-1:0]                   flit;
    logic [NetworkIfFlitTypeWidth-1:0]               ftype;
    logic [NetworkIfBroadcastWidth-1:0]              flit_bcast;
    logic [NetworkIfVirtualNetworkIdWidth-1:0]       flit_vn;
    logic                                            ready;
    logic                                            accept;
    logic                                            is_head;
    logic                                            restart;
    logic                                            out_valid;

    // Field unpacking of the ejector word (LSB first: flit, type, broadcast, vn).
    assign flit       = bus.data_i[0 +: NetworkIfFlitWidth];
    assign ftype      = bus.data_i[TypeLsb +: NetworkIfFlitTypeWidth];
    assign flit_bcast = bus.data_i[BcastLsb +: NetworkIfBroadcastWidth];
    assign flit_vn    = bus.data_i[VnLsb +: NetworkIfVirtualNetworkIdWidth];

    // Ready is a pure function of state so the ejector never sees a
    // combinational path from its own valid or from the sink's ready.
    assign ready     = (state_q != OUTPUT);
    assign accept    = bus.valid_i && ready;
    assign is_head   = (ftype == FtHeader) || (ftype == FtHeaderTail);
    assign out_valid = (state_q == OUTPUT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        slots_d = slots_q;
        bcast_d = bcast_q;
        vn_d    = vn_q;
        error_d = 1'b0;
        restart = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    restart = 1'b1;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (is_head) begin
                        // Truncated packet: drop it and treat the new header
                        // as if it arrived in IDLE.
                        error_d = 1'b1;
                        restart = 1'b1;
                    end else if (flit_vn != vn_q) begin
                        error_d = 1'b1;
                    end else if (count_q < MaxCount) begin
                        slots_d[count_q[SlotIdxWidth-1:0]] = flit;
                        count_d = count_q + CountWidth'(1);
                        if (ftype == FtTail) begin
                            state_d = OUTPUT;
                        end
                    end else begin
                        // Overlong packet: a tail closes it right here, a
                        // payload means the rest must be skipped up to the tail.
                        error_d = 1'b1;
                        count_d = '0;
                        state_d = (ftype == FtTail) ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (is_head) begin
                        error_d = 1'b1;
                        restart = 1'b1;
                    end else if (ftype == FtTail) begin
                        state_d = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (bus.packet_ready_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // Shared "process as in IDLE" path for IDLE, COLLECT and DROP.
        if (restart) begin
            if (is_head) begin
                slots_d    = '0;
                slots_d[0] = flit;
                count_d    = CountWidth'(1);
                bcast_d    = flit_bcast;
                vn_d       = flit_vn;
                state_d    = (ftype == FtHeaderTail) ? OUTPUT : COLLECT;
            end else begin
                error_d = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            bcast_q <= '0;
            vn_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcast_q <= bcast_d;
            vn_q    <= vn_d;
            error_q <= error_d;
        end
    end

    // Slot storage is pure data; its contents are never visible unless the
    // FSM is in OUTPUT with a matching count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        slots_q <= slots_d;
    end

    // Packet outputs read as zero outside OUTPUT and beyond the flit count.
    always_comb begin
        bus.packet_data_o = '0;
        for (int k = 0; k < MaxFlitsPerPacket; k++) begin
            if (out_valid && (CountWidth'(k) < count_q)) begin
                bus.packet_data_o[k*NetworkIfFlitWidth +: NetworkIfFlitWidth] = slots_q[k];
            end
        end
    end

    assign bus.ready_o                     = ready;
    assign bus.packet_valid_o              = out_valid;
    assign bus.packet_num_flits_o          = out_valid ? count_q : '0;
    assign bus.packet_broadcast_o          = out_valid ? bcast_q : '0;
    assign bus.packet_virtual_network_id_o = out_valid ? vn_q : '0;
    assign bus.error_o                     = error_q;

endmodule

// File: tb/tb_network_packet_assembler.sv
// -----------------------------------------------------------------------------
// tb_network_packet_assembler
//
// Purpose : Self-checking bench for network_packet_assembler. Expected packets
//           are queued when their flits are driven and compared when the sink
//           accepts them; error pulses and ready-low cycles are counted and
//           compared against per-scenario expectations.
// -----------------------------------------------------------------------------
module tb_network_packet_assembler;
    localparam int FW   = 64;
    localparam int TW   = 2;
    localparam int BW   = 1;
    localparam int VW   = 2;
    localparam int MAXF = 4;
    localparam int PW   = MAXF * FW;
    localparam int CW   = $clog2(MAXF + 1);

    localparam logic [1:0] T_H  = 2'd0;
    localparam logic [1:0] T_P  = 2'd1;
    localparam logic [1:0] T_T  = 2'd2;
    localparam logic [1:0] T_HT = 2'd3;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [CW-1:0] n;
        logic          bc;
        logic [VW-1:0] vn;
    } pkt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    network_packet_assembler_if #(
        .NetworkIfFlitWidth(FW),
        .NetworkIfFlitTypeWidth(TW),
        .NetworkIfBroadcastWidth(BW),
        .NetworkIfVirtualNetworkIdWidth(VW),
        .MaxFlitsPerPacket(MAXF)
    ) bus ();

    network_packet_assembler #(
        .NetworkIfFlitWidth(FW),
        .NetworkIfFlitTypeWidth(TW),
        .NetworkIfBroadcastWidth(BW),
        .NetworkIfVirtualNetworkIdWidth(VW),
        .MaxFlitsPerPacket(MAXF)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    pkt_t sb[$];
    int   n_checks  = 0;
    int   n_bad     = 0;
    int   err_seen  = 0;
    int   ready_low = 0;
    int   pkts_seen = 0;

    task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    logic          hold_q = 1'b0;
    logic [PW-1:0] hold_data;
    logic [CW-1:0] hold_n;
    logic          hold_bc;
    logic [VW-1:0] hold_vn;

    always @(negedge clk) begin
        pkt_t e;
        if (!rst) begin
            if (bus.error_o) err_seen++;
            if (!bus.ready_o) ready_low++;
            if (hold_q) begin
                check_eq("hold_valid", bus.packet_valid_o, 1'b1);
                check_eq("hold_data", bus.packet_data_o, hold_data);
                check_eq("hold_n", bus.packet_num_flits_o, hold_n);
                check_eq("hold_bc", bus.packet_broadcast_o, hold_bc);
                check_eq("hold_vn", bus.packet_virtual_network_id_o, hold_vn);
            end
            if (bus.packet_valid_o && bus.packet_ready_i) begin
                pkts_seen++;
                check_eq("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("pkt_data", bus.packet_data_o, e.data);
                    check_eq("pkt_n", bus.packet_num_flits_o, e.n);
                    check_eq("pkt_bc", bus.packet_broadcast_o, e.bc);
                    check_eq("pkt_vn", bus.packet_virtual_network_id_o, e.vn);
                end
            end
            hold_q    = bus.packet_valid_o && !bus.packet_ready_i;
            hold_data = bus.packet_data_o;
            hold_n    = bus.packet_num_flits_o;
            hold_bc   = bus.packet_broadcast_o;
            hold_vn   = bus.packet_virtual_network_id_o;
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [VW-1:0] vn, input logic bc,
                        input logic [FW-1:0] f);
        int waited;
        waited = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = {vn, bc, t, f};
        while (!bus.ready_o && waited < 50) begin
            tick(1);
            waited++;
        end
        check_eq("ready_wait", bus.ready_o, 1'b1);
        tick(1);
        bus.valid_i = 1'b0;
    endtask

    task automatic push(input logic [PW-1:0] d, input int n, input logic bc, input logic [VW-1:0] vn);
        pkt_t p;
        p.data = d;
        p.n    = CW'(n);
        p.bc   = bc;
        p.vn   = vn;
        sb.push_back(p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1, "bench timed out");
    end

    initial begin
        int e0, r0, p0;
        bus.valid_i        = 1'b0;
        bus.data_i         = '0;
        bus.packet_ready_i = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state, first cycle after reset release.
        check_eq("rst_ready", bus.ready_o, 1'b1);
        check_eq("rst_valid", bus.packet_valid_o, 1'b0);
        check_eq("rst_data", bus.packet_data_o, '0);
        check_eq("rst_n", bus.packet_num_flits_o, '0);
        check_eq("rst_bc", bus.packet_broadcast_o, '0);
        check_eq("rst_vn", bus.packet_virtual_network_id_o, '0);
        check_eq("rst_err", bus.error_o, 1'b0);

        // Three-flit packet, broadcast, VN 2, always-ready sink.
        e0 = err_seen; r0 = ready_low; p0 = pkts_seen;
        push({64'h0, 64'hC, 64'hB, 64'hA}, 3, 1'b1, 2'd2);
        send(T_H, 2'd2, 1'b1, 64'hA);
        send(T_P, 2'd2, 1'b1, 64'hB);
        send(T_T, 2'd2, 1'b1, 64'hC);
        check_eq("t1_latency", bus.packet_valid_o, 1'b1);
        tick(3);
        check_eq("t1_err", err_seen - e0, 0);
        check_eq("t1_ready_low", ready_low - r0, 1);
        check_eq("t1_pkts", pkts_seen - p0, 1);

        // Single-flit packet held by a stalled sink.
        e0 = err_seen; p0 = pkts_seen;
        bus.packet_ready_i = 1'b0;
        push({192'h0, 64'h55}, 1, 1'b0, 2'd0);
        send(T_HT, 2'd0, 1'b0, 64'h55);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_valid", bus.packet_valid_o, 1'b1);
            check_eq("t2_ready", bus.ready_o, 1'b0);
            tick(1);
        end
        bus.packet_ready_i = 1'b1;
        tick(1);
        check_eq("t2_ready_after", bus.ready_o, 1'b1);
        check_eq("t2_valid_after", bus.packet_valid_o, 1'b0);
        check_eq("t2_pkts", pkts_seen - p0, 1);
        check_eq("t2_err", err_seen - e0, 0);

        // Orphan payload and tail in IDLE.
        e0 = err_seen; r0 = ready_low; p0 = pkts_seen;
        send(T_P, 2'd1, 1'b0, 64'h1234);
        send(T_T, 2'd1, 1'b0, 64'h5678);
        tick(3);
        check_eq("t3_err", err_seen - e0, 2);
        check_eq("t3_ready_low", ready_low - r0, 0);
        check_eq("t3_pkts", pkts_seen - p0, 0);

        // Overlong packet: header + 4 payloads + tail.
        e0 = err_seen; p0 = pkts_seen;
        send(T_H, 2'd1, 1'b0, 64'h10);
        for (int i = 0; i < 4; i++) send(T_P, 2'd1, 1'b0, 64'h20 + 64'(i));
        send(T_T, 2'd1, 1'b0, 64'h30);
        tick(3);
        check_eq("t4_err", err_seen - e0, 1);
        check_eq("t4_pkts", pkts_seen - p0, 0);
        e0 = err_seen; p0 = pkts_seen;
        push({192'h0, 64'h77}, 1, 1'b1, 2'd3);
        send(T_HT, 2'd3, 1'b1, 64'h77);
        tick(3);
        check_eq("t4b_err", err_seen - e0, 0);
        check_eq("t4b_pkts", pkts_seen - p0, 1);

        // VN mismatch in the middle of a packet.
        e0 = err_seen; p0 = pkts_seen;
        push({128'h0, 64'h33, 64'h11}, 2, 1'b0, 2'd1);
        send(T_H, 2'd1, 1'b0, 64'h11);
        send(T_P, 2'd3, 1'b0, 64'h22);
        send(T_T, 2'd1, 1'b0, 64'h33);
        tick(3);
        check_eq("t5_err", err_seen - e0, 1);
        check_eq("t5_pkts", pkts_seen - p0, 1);

        // Second header truncates the first packet.
        e0 = err_seen; p0 = pkts_seen;
        push({64'h0, 64'h4, 64'h3, 64'h2}, 3, 1'b0, 2'd0);
        send(T_H, 2'd0, 1'b0, 64'h1);
        send(T_H, 2'd0, 1'b0, 64'h2);
        send(T_P, 2'd0, 1'b0, 64'h3);
        send(T_T, 2'd0, 1'b0, 64'h4);
        tick(3);
        check_eq("t6_err", err_seen - e0, 1);
        check_eq("t6_pkts", pkts_seen - p0, 1);

        // Reset in the middle of a packet.
        e0 = err_seen; p0 = pkts_seen;
        send(T_H, 2'd2, 1'b1, 64'h99);
        send(T_P, 2'd2, 1'b1, 64'h98);
        rst = 1'b1;
        tick(1);
        check_eq("t7_valid", bus.packet_valid_o, 1'b0);
        check_eq("t7_data", bus.packet_data_o, '0);
        check_eq("t7_n", bus.packet_num_flits_o, '0);
        check_eq("t7_bc", bus.packet_broadcast_o, '0);
        check_eq("t7_vn", bus.packet_virtual_network_id_o, '0);
        check_eq("t7_err_out", bus.error_o, 1'b0);
        check_eq("t7_ready", bus.ready_o, 1'b1);
        rst = 1'b0;
        push({192'h0, 64'hAB}, 1, 1'b0, 2'd1);
        send(T_HT, 2'd1, 1'b0, 64'hAB);
        tick(3);
        check_eq("t7_err", err_seen - e0, 0);
        check_eq("t7_pkts", pkts_seen - p0, 1);

        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
